// File: rtl/aidc_lite_ahb_arbiter.sv
// Round-robin AHB2 arbiter for the AIDC-Lite masters. Grants are frozen while a
// fixed-length burst runs on the muxed bus; master 0 is parked on after reset.
module aidc_lite_ahb_arbiter #(
    parameter int unsigned NUM_MST = 3,
    parameter int unsigned IDX_W   = $clog2(NUM_MST)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_MST-1:0] hbusreq_i,
    output logic [NUM_MST-1:0] hgrant_o,
    input  logic [1:0]         htrans_i,
    input  logic [2:0]         hburst_i,
    input  logic               hready_i,
    output logic [IDX_W-1:0]   hmaster_o,
    output logic [IDX_W-1:0]   hmaster_data_o,
    output logic               burst_active_o
);

    localparam logic [1:0] TransIdle   = 2'd0;
    localparam logic [1:0] TransBusy   = 2'd1;
    localparam logic [1:0] TransNonseq = 2'd2;
    localparam logic [1:0] TransSeq    = 2'd3;

    typedef enum logic {StOpen, StBurst} state_e;

    state_e             state_q, state_d;
    logic [3:0]         beats_q, beats_d;
    logic [IDX_W-1:0]   grant_idx_q;
    logic [IDX_W-1:0]   last_idx_q;
    logic [IDX_W-1:0]   next_idx;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic               rearb;
    logic [4:0]         burst_len;

    // INCR has no known length, so it is treated as a run of single beats.
    always_comb begin
        burst_len = 5'd1;
        case (hburst_i)
            3'd2, 3'd3: burst_len = 5'd4;
            3'd4, 3'd5: burst_len = 5'd8;
            3'd6, 3'd7: burst_len = 5'd16;
            default:    burst_len = 5'd1;
        endcase
    end

    // Round-robin scan starting just after the last winner; parks if nobody asks.
    always_comb begin
        next_idx = grant_idx_q;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NUM_MST; k++) begin
            cand = IDX_W'((32'(last_idx_q) + k) % NUM_MST);
            if (!found && hbusreq_i[cand]) begin
                next_idx = cand;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        rearb   = 1'b0;
        unique case (state_q)
            StOpen: begin
                if (htrans_i == TransNonseq && burst_len > 5'd1) begin
                    state_d = StBurst;
                    beats_d = 4'(burst_len - 5'd1);
                end else begin
                    rearb = 1'b1;
                end
            end
            StBurst: begin
                case (htrans_i)
                    TransSeq: begin
                        if (beats_q <= 4'd1) begin
                            state_d = StOpen;
                            beats_d = 4'd0;
                            rearb   = 1'b1;
                        end else begin
                            beats_d = beats_q - 4'd1;
                        end
                    end
                    TransBusy: beats_d = beats_q;
                    TransNonseq: begin
                        if (burst_len > 5'd1) begin
                            beats_d = 4'(burst_len - 5'd1);
                        end else begin
                            state_d = StOpen;
                            beats_d = 4'd0;
                            rearb   = 1'b1;
                        end
                    end
                    default: begin
                        state_d = StOpen;
                        beats_d = 4'd0;
                        rearb   = 1'b1;
                    end
                endcase
            end
            default: begin
                state_d = StOpen;
                beats_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StOpen;
            beats_q        <= 4'd0;
            grant_idx_q    <= '0;
            last_idx_q     <= '0;
            hgrant_o       <= {{(NUM_MST-1){1'b0}}, 1'b1};
            hmaster_o      <= '0;
            hmaster_data_o <= '0;
            burst_active_o <= 1'b0;
        end else if (hready_i) begin
            state_q        <= state_d;
            beats_q        <= beats_d;
            burst_active_o <= (state_d == StBurst);
            if (rearb) begin
                grant_idx_q <= next_idx;
                last_idx_q  <= next_idx;
                hgrant_o    <= {{(NUM_MST-1){1'b0}}, 1'b1} << next_idx;
            end
            // Address owner lags the grant by one hready edge; data owner lags address.
            hmaster_o      <= grant_idx_q;
            hmaster_data_o <= hmaster_o;
        end
    end

endmodule

// File: tb/tb_aidc_lite_ahb_arbiter.sv
// Directed bench for aidc_lite_ahb_arbiter: reset, bursts, contention, round-robin,
// stalls/BUSY, early termination and reset mid-burst.
module tb_aidc_lite_ahb_arbiter;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] hbusreq;
    logic [2:0] hgrant;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hmaster;
    logic [1:0] hmaster_data;
    logic       burst_active;

    int total = 0;
    int bad   = 0;

    aidc_lite_ahb_arbiter #(.NUM_MST(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hbusreq_i      (hbusreq),
        .hgrant_o       (hgrant),
        .htrans_i       (htrans),
        .hburst_i       (hburst),
        .hready_i       (hready),
        .hmaster_o      (hmaster),
        .hmaster_data_o (hmaster_data),
        .burst_active_o (burst_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    end

    initial begin
        int hi;
        int exp_order[7];
        exp_order = '{1, 2, 0, 1, 2, 0, 1};

        // Reset
        rst_n = 1'b0; hbusreq = 3'b000; htrans = IDLE; hburst = 3'd0; hready = 1'b1;
        repeat (3) tick();
        chk("rst_grant", 32'(hgrant), 32'h1);
        chk("rst_hmaster", 32'(hmaster), 32'h0);
        chk("rst_hmaster_data", 32'(hmaster_data), 32'h0);
        chk("rst_burst", 32'(burst_active), 32'h0);
        rst_n = 1'b1;
        repeat (6) tick();
        chk("park_grant", 32'(hgrant), 32'h1);

        // Single requester INCR16, master drops hbusreq in its address phase
        hbusreq = 3'b010;
        tick();
        chk("single_grant", 32'(hgrant), 32'h2);
        chk("single_hmaster_lag", 32'(hmaster), 32'h0);
        tick();
        chk("single_hmaster", 32'(hmaster), 32'h1);
        chk("single_hdata_lag", 32'(hmaster_data), 32'h0);
        htrans = NONSEQ; hburst = 3'd7; hbusreq = 3'b000;
        tick();
        hi = burst_active ? 1 : 0;
        chk("single_hdata", 32'(hmaster_data), 32'h1);
        htrans = SEQ;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (burst_active) hi++;
        end
        chk("single_burst_cycles", 32'(hi), 32'd15);
        chk("single_grant_end", 32'(hgrant), 32'h2);

        // Contention: master 2 requests at beat 3 of master 1's INCR16
        hbusreq = 3'b010; htrans = NONSEQ; hburst = 3'd7;
        tick();
        htrans = SEQ;
        tick();
        hbusreq = 3'b110;
        for (int b = 3; b <= 15; b++) tick();
        chk("cont_grant_b15", 32'(hgrant), 32'h2);
        chk("cont_burst_b15", 32'(burst_active), 32'h1);
        tick();
        chk("cont_grant_b16", 32'(hgrant), 32'h4);
        chk("cont_hmaster_b16", 32'(hmaster), 32'h1);
        chk("cont_burst_b16", 32'(burst_active), 32'h0);
        htrans = IDLE; hbusreq = 3'b100;
        tick();
        chk("cont_hmaster_next", 32'(hmaster), 32'h2);
        chk("cont_hdata_next", 32'(hmaster_data), 32'h1);

        // Round-robin with everyone requesting, back-to-back INCR16
        rst_n = 1'b0; hbusreq = 3'b000;
        tick();
        rst_n = 1'b1; hbusreq = 3'b111;
        tick();
        chk("rr_first_grant", 32'(hgrant), 32'h2);
        for (int r = 0; r < 6; r++) begin
            htrans = NONSEQ; hburst = 3'd7;
            tick();
            chk("rr_grant_start", 32'(hgrant), 32'h1 << exp_order[r]);
            chk("rr_hmaster", 32'(hmaster), 32'(exp_order[r]));
            htrans = SEQ;
            repeat (14) tick();
            chk("rr_grant_hold", 32'(hgrant), 32'h1 << exp_order[r]);
            tick();
            chk("rr_grant_next", 32'(hgrant), 32'h1 << exp_order[r + 1]);
        end

        // INCR4 with 5 wait states at beat 2 and BUSY at beat 3
        htrans = IDLE; hbusreq = 3'b010;
        tick();
        chk("ws_grant", 32'(hgrant), 32'h2);
        htrans = NONSEQ; hburst = 3'd3; hbusreq = 3'b110;
        tick();
        chk("ws_burst_b1", 32'(burst_active), 32'h1);
        htrans = SEQ; hready = 1'b0;
        repeat (5) tick();
        chk("ws_stall_grant", 32'(hgrant), 32'h2);
        chk("ws_stall_burst", 32'(burst_active), 32'h1);
        chk("ws_stall_hmaster", 32'(hmaster), 32'h1);
        hready = 1'b1;
        tick();
        htrans = BUSY;
        tick();
        chk("ws_busy_grant", 32'(hgrant), 32'h2);
        chk("ws_busy_burst", 32'(burst_active), 32'h1);
        htrans = SEQ;
        tick();
        chk("ws_b3_burst", 32'(burst_active), 32'h1);
        chk("ws_b3_grant", 32'(hgrant), 32'h2);
        tick();
        chk("ws_b4_burst", 32'(burst_active), 32'h0);
        chk("ws_b4_grant", 32'(hgrant), 32'h4);

        // Early termination of INCR8 by IDLE at beat 6 with master 0 waiting
        htrans = NONSEQ; hburst = 3'd5; hbusreq = 3'b101;
        tick();
        chk("et_grant_b1", 32'(hgrant), 32'h4);
        htrans = SEQ;
        repeat (4) tick();
        chk("et_grant_b5", 32'(hgrant), 32'h4);
        chk("et_burst_b5", 32'(burst_active), 32'h1);
        htrans = IDLE;
        tick();
        chk("et_grant_idle", 32'(hgrant), 32'h1);
        chk("et_burst_idle", 32'(burst_active), 32'h0);

        // Reset mid-burst
        hbusreq = 3'b010;
        tick();
        htrans = NONSEQ; hburst = 3'd5;
        tick();
        htrans = SEQ;
        tick();
        chk("mr_pre_grant", 32'(hgrant), 32'h2);
        chk("mr_pre_hdata", 32'(hmaster_data), 32'h1);
        rst_n = 1'b0;
        tick();
        chk("mr_grant", 32'(hgrant), 32'h1);
        chk("mr_hmaster", 32'(hmaster), 32'h0);
        chk("mr_hdata", 32'(hmaster_data), 32'h0);
        chk("mr_burst", 32'(burst_active), 32'h0);
        rst_n = 1'b1; hbusreq = 3'b000;
        tick();
        chk("mr_open_after", 32'(burst_active), 32'h0);
        htrans = IDLE; hbusreq = 3'b110;
        tick();
        chk("mr_last_idx", 32'(hgrant), 32'h2);

        // SINGLE NONSEQ never enters a burst
        htrans = NONSEQ; hburst = 3'd0;
        tick();
        chk("single_beat_burst", 32'(burst_active), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
